// File: rtl/bp_pkg.sv
// bp_pkg: shared definitions for the fetch-stage branch predictor.
//   - 2-bit saturating counter encodings (SNT/WNT/WT/ST); a counter
//     predicts taken when its MSB is set.
//   - bp_index / bp_tag: carve the BTB index and tag fields out of a PC.
//     PCs are passed zero-extended to BP_PC_W bits so one function body
//     serves every XLEN; callers cast the result down to IDX / TAG_BITS.
//   - ctr_next: saturating counter update.
package bp_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam int unsigned BP_PC_W = 64;

  // Index is the word address modulo the table depth: PC[IDX+1:2].
  function automatic logic [31:0] bp_index(input logic [BP_PC_W-1:0] pc,
                                           input int unsigned idx_bits);
    logic [BP_PC_W-1:0] mask;
    mask = (64'd1 << idx_bits) - 64'd1;
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag sits directly above the index field: PC[IDX+1+TAG_BITS:IDX+2].
  function automatic logic [31:0] bp_tag(input logic [BP_PC_W-1:0] pc,
                                         input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    logic [BP_PC_W-1:0] mask;
    mask = (64'd1 << tag_bits) - 64'd1;
    return 32'((pc >> (idx_bits + 32'd2)) & mask);
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr,
                                          input logic       taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_table.sv
// bp_table: direct-mapped BTB storage with one combinational lookup port
// and one resolve/update port. Every field is a flop so the whole table
// can be reset and bulk-invalidated in a single edge.
// Ports:
//   clk          in  1     clock
//   rst_n        in  1     asynchronous reset, active-low
//   rd_pc        in  XLEN  lookup PC
//   rd_hit       out 1     valid entry with matching tag
//   rd_ctr_taken out 1     counter MSB of the indexed entry
//   rd_target    out XLEN  stored target of the indexed entry
//   wr_en        in  1     a resolved branch/jump updates the table this edge
//   wr_pc        in  XLEN  PC of the resolved instruction
//   wr_taken     in  1     resolved direction (jumps already folded in)
//   wr_jump      in  1     resolved instruction is unconditional
//   wr_target    in  XLEN  resolved target
//   flush_all    in  1     invalidate every entry; drops a same-edge update
module bp_table
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc,
  output logic            rd_hit,
  output logic            rd_ctr_taken,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic            wr_jump,
  input  logic [XLEN-1:0] wr_target,
  input  logic            flush_all
);

  localparam int unsigned IDX = $clog2(ENTRIES);

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [XLEN-1:0]     target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [IDX-1:0]      rd_idx;
  logic [TAG_BITS-1:0] rd_tag;
  logic [IDX-1:0]      wr_idx;
  logic [TAG_BITS-1:0] wr_tag;
  logic                wr_hit;

  assign rd_idx = IDX'(bp_index(BP_PC_W'(rd_pc), IDX));
  assign rd_tag = TAG_BITS'(bp_tag(BP_PC_W'(rd_pc), IDX, TAG_BITS));
  assign wr_idx = IDX'(bp_index(BP_PC_W'(wr_pc), IDX));
  assign wr_tag = TAG_BITS'(bp_tag(BP_PC_W'(wr_pc), IDX, TAG_BITS));

  // Lookup reads the current flops, so a lookup in the same cycle as an
  // update of the same index sees the pre-update contents.
  assign rd_hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr_taken = ctr_q[rd_idx][1];
  assign rd_target    = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush_all) begin
      valid_d = '0;
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_d[wr_idx] = ctr_next(ctr_q[wr_idx], wr_taken);
        if (wr_taken) target_d[wr_idx] = wr_target;
      end else if (wr_taken) begin
        // Allocation (also evicts an aliasing entry). Jumps always go the
        // same way, so they start fully saturated.
        valid_d[wr_idx]  = 1'b1;
        tag_d[wr_idx]    = wr_tag;
        target_d[wr_idx] = wr_target;
        ctr_d[wr_idx]    = wr_jump ? ST : WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

endmodule

// File: rtl/dffREC.sv
// dffREC: W-bit pipeline register with enable, synchronous clear and
// asynchronous active-low reset. Clear wins over enable, so a flush also
// empties a stalled stage.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous reset, active-low (register -> 0)
//   en    in  1  load d when high
//   clr   in  1  load 0 when high (priority over en)
//   d     in  W  next value
//   q     out W  registered value
module dffREC #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: fetch-stage dynamic predictor (BTB + 2-bit counters).
// Supplies the IF PC mux with a predicted next PC, carries the prediction
// through IF/ID and ID/EX, and in EX checks it against the resolved outcome.
// Ei_resolve is a single-cycle qualifier with no backpressure: every cycle
// it is high, the Ei_* fields describe one resolved control transfer and
// the table is updated at that cycle's rising edge.
// Ports:
//   clk, reset_x                clock; asynchronous active-low reset
//   Fi_PC / Fo_predTaken /
//   Fo_predTarget               combinational lookup of the fetch PC
//   Di_stall / Di_flush         hold / clear the IF/ID prediction register
//   Ei_flush                    clear the ID/EX prediction register
//   Ci_btbFlush                 invalidate the whole table (fence.i)
//   Ei_resolve, Ei_isJump,
//   Ei_taken, Ei_PC, Ei_target  resolved control transfer in EX
//   Eo_predTaken                prediction carried into EX
//   Eo_mispredict               EX outcome differs from that prediction
//   Eo_redirectPC               correct next PC for the redirect
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned TAG_BITS = 8
) (
  input  logic            clk,
  input  logic            reset_x,
  input  logic [XLEN-1:0] Fi_PC,
  output logic            Fo_predTaken,
  output logic [XLEN-1:0] Fo_predTarget,
  input  logic            Di_stall,
  input  logic            Di_flush,
  input  logic            Ei_flush,
  input  logic            Ci_btbFlush,
  input  logic            Ei_resolve,
  input  logic            Ei_isJump,
  input  logic            Ei_taken,
  input  logic [XLEN-1:0] Ei_PC,
  input  logic [XLEN-1:0] Ei_target,
  output logic            Eo_predTaken,
  output logic            Eo_mispredict,
  output logic [XLEN-1:0] Eo_redirectPC
);

  localparam int unsigned PW = XLEN + 1;

  logic            lk_hit;
  logic            lk_ctr_taken;
  logic [XLEN-1:0] lk_target;

  logic [PW-1:0]   ifid_q;
  logic [PW-1:0]   idex_q;
  logic [XLEN-1:0] ex_pred_target;
  logic            ex_taken;

  bp_table #(
    .XLEN     (XLEN),
    .ENTRIES  (ENTRIES),
    .TAG_BITS (TAG_BITS)
  ) u_table (
    .clk          (clk),
    .rst_n        (reset_x),
    .rd_pc        (Fi_PC),
    .rd_hit       (lk_hit),
    .rd_ctr_taken (lk_ctr_taken),
    .rd_target    (lk_target),
    .wr_en        (Ei_resolve),
    .wr_pc        (Ei_PC),
    .wr_taken     (ex_taken),
    .wr_jump      (Ei_isJump),
    .wr_target    (Ei_target),
    .flush_all    (Ci_btbFlush)
  );

  assign Fo_predTaken  = lk_hit & lk_ctr_taken;
  assign Fo_predTarget = Fo_predTaken ? lk_target : Fi_PC + XLEN'(4);

  // Prediction travels as {taken, target} alongside the instruction.
  dffREC #(.W(PW)) u_ifid (
    .clk   (clk),
    .rst_n (reset_x),
    .en    (~Di_stall),
    .clr   (Di_flush),
    .d     ({Fo_predTaken, Fo_predTarget}),
    .q     (ifid_q)
  );

  dffREC #(.W(PW)) u_idex (
    .clk   (clk),
    .rst_n (reset_x),
    .en    (1'b1),
    .clr   (Ei_flush),
    .d     (ifid_q),
    .q     (idex_q)
  );

  assign Eo_predTaken   = idex_q[XLEN];
  assign ex_pred_target = idex_q[XLEN-1:0];

  assign ex_taken = Ei_taken | Ei_isJump;

  // A correctly predicted taken transfer must also have gone to the right
  // place; a not-taken prediction carries PC+4, which is never compared.
  assign Eo_mispredict = Ei_resolve &
                         ((Eo_predTaken != ex_taken) |
                          (ex_taken & (ex_pred_target != Ei_target)));

  assign Eo_redirectPC = ex_taken ? Ei_target : Ei_PC + XLEN'(4);

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (XLEN=32, ENTRIES=16, TAG_BITS=8).
// Each scenario task drives stimulus, records the expected output vector
// and a field mask in the scoreboard queues together with the observed
// vector, then drains the queues with its own comparisons.
// Vector layout: {Fo_predTaken, Fo_predTarget, Eo_predTaken,
//                 Eo_mispredict, Eo_redirectPC}.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int W    = 2 * XLEN + 3;

  localparam logic [W-1:0] M_F  = {1'b1, 32'hFFFF_FFFF, 34'h0};
  localparam logic [W-1:0] M_ET = {33'h0, 1'b1, 33'h0};
  localparam logic [W-1:0] M_EM = {34'h0, 1'b1, 32'h0};
  localparam logic [W-1:0] M_ER = {35'h0, 32'hFFFF_FFFF};
  localparam logic [W-1:0] M_E  = M_ET | M_EM | M_ER;

  logic            clk = 1'b0;
  logic            reset_x;
  logic [XLEN-1:0] Fi_PC;
  logic            Fo_predTaken;
  logic [XLEN-1:0] Fo_predTarget;
  logic            Di_stall;
  logic            Di_flush;
  logic            Ei_flush;
  logic            Ci_btbFlush;
  logic            Ei_resolve;
  logic            Ei_isJump;
  logic            Ei_taken;
  logic [XLEN-1:0] Ei_PC;
  logic [XLEN-1:0] Ei_target;
  logic            Eo_predTaken;
  logic            Eo_mispredict;
  logic [XLEN-1:0] Eo_redirectPC;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  logic [W-1:0] obs_q[$];
  string        name_q[$];

  int checks   = 0;
  int failures = 0;

  branch_predictor #(
    .XLEN     (32),
    .ENTRIES  (16),
    .TAG_BITS (8)
  ) dut (
    .clk           (clk),
    .reset_x       (reset_x),
    .Fi_PC         (Fi_PC),
    .Fo_predTaken  (Fo_predTaken),
    .Fo_predTarget (Fo_predTarget),
    .Di_stall      (Di_stall),
    .Di_flush      (Di_flush),
    .Ei_flush      (Ei_flush),
    .Ci_btbFlush   (Ci_btbFlush),
    .Ei_resolve    (Ei_resolve),
    .Ei_isJump     (Ei_isJump),
    .Ei_taken      (Ei_taken),
    .Ei_PC         (Ei_PC),
    .Ei_target     (Ei_target),
    .Eo_predTaken  (Eo_predTaken),
    .Eo_mispredict (Eo_mispredict),
    .Eo_redirectPC (Eo_redirectPC)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] pk(input logic ft, input logic [31:0] ftgt,
                                      input logic et, input logic em,
                                      input logic [31:0] er);
    return {ft, ftgt, et, em, er};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Di_stall    = 1'b0;
    Di_flush    = 1'b0;
    Ei_flush    = 1'b0;
    Ci_btbFlush = 1'b0;
    Ei_resolve  = 1'b0;
    Ei_isJump   = 1'b0;
    Ei_taken    = 1'b0;
    Ei_PC       = '0;
    Ei_target   = '0;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken,
                         input logic jump, input logic [31:0] tgt);
    Ei_resolve = 1'b1;
    Ei_PC      = pc;
    Ei_taken   = taken;
    Ei_isJump  = jump;
    Ei_target  = tgt;
  endtask

  // Records expectation and observation; the calling test compares.
  task automatic sample(input logic [W-1:0] e, input logic [W-1:0] m, input string n);
    #1;
    exp_q.push_back(e);
    msk_q.push_back(m);
    name_q.push_back(n);
    obs_q.push_back({Fo_predTaken, Fo_predTarget, Eo_predTaken, Eo_mispredict, Eo_redirectPC});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] e, m, o;
    string n;
    reset_x = 1'b0;
    idle();
    Fi_PC = 32'h10000;
    Ei_taken = 1'b1;
    Ei_target = 32'h10100;
    @(posedge clk);
    #2;
    sample(pk(1'b0, 32'h10004, 1'b0, 1'b0, 32'h10100), M_F | M_E, "reset_state");
    reset_x = 1'b1;
    next_cycle(); idle(); Fi_PC = 32'h10000;
    sample(pk(1'b0, 32'h10004, 1'b0, 1'b0, 32'h4), M_F | M_E, "reset_lookup");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_alloc();
    logic [W-1:0] e, m, o;
    string n;
    next_cycle(); idle();
    Fi_PC = 32'h10010;
    resolve(32'h10010, 1'b1, 1'b0, 32'h10100);
    sample(pk(1'b0, 32'h10014, 1'b0, 1'b1, 32'h10100), M_F | M_E, "alloc_same_cycle");
    next_cycle(); idle(); Fi_PC = 32'h10010;
    sample(pk(1'b1, 32'h10100, 1'b0, 1'b0, 32'h0), M_F, "alloc_hit");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_counter();
    logic [W-1:0] e, m, o;
    string n;
    logic        st_taken [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] st_tgt   [8] = '{32'h1dead0, 32'h1dead0, 32'h10100, 32'h10100,
                                  32'h10100, 32'h10200, 32'h1dead0, 32'h1dead0};
    logic        ex_pt    [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ex_tgt   [8] = '{32'h10014, 32'h10014, 32'h10014, 32'h10100,
                                  32'h10100, 32'h10200, 32'h10200, 32'h10014};
    for (int i = 0; i < 8; i++) begin
      next_cycle(); idle(); Fi_PC = 32'h20000;
      resolve(32'h10010, st_taken[i], 1'b0, st_tgt[i]);
      next_cycle(); idle(); Fi_PC = 32'h10010;
      sample(pk(ex_pt[i], ex_tgt[i], 1'b0, 1'b0, 32'h0), M_F, $sformatf("ctr_step%0d", i));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_alias();
    logic [W-1:0] e, m, o;
    string n;
    // 0x10010 and 0x10050 share index 4; tags 0 and 1.
    next_cycle(); idle(); Fi_PC = 32'h20000;
    resolve(32'h10010, 1'b1, 1'b0, 32'h10200);
    next_cycle(); idle(); Fi_PC = 32'h10010;
    sample(pk(1'b1, 32'h10200, 1'b0, 1'b0, 32'h0), M_F, "alias_before");
    Fi_PC = 32'h10050;
    sample(pk(1'b0, 32'h10054, 1'b0, 1'b0, 32'h0), M_F, "alias_miss");
    resolve(32'h10050, 1'b1, 1'b0, 32'h10300);
    next_cycle(); idle(); Fi_PC = 32'h10010;
    sample(pk(1'b0, 32'h10014, 1'b0, 1'b0, 32'h0), M_F, "alias_evicted");
    Fi_PC = 32'h10050;
    sample(pk(1'b1, 32'h10300, 1'b0, 1'b0, 32'h0), M_F, "alias_new");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_ex_compare();
    logic [W-1:0] e, m, o;
    string n;
    next_cycle(); idle(); Fi_PC = 32'h10050;
    next_cycle(); idle(); Fi_PC = 32'h20000;
    next_cycle(); idle(); Fi_PC = 32'h20000;
    // ID/EX now carries {1, 0x10300}.
    resolve(32'h10050, 1'b1, 1'b0, 32'h10300);
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h10300), M_E, "ex_correct");
    Ei_target = 32'h10304;
    sample(pk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10304), M_E, "ex_wrong_target");
    Ei_taken = 1'b0; Ei_target = 32'h10300;
    sample(pk(1'b0, 32'h0, 1'b1, 1'b1, 32'h10054), M_E, "ex_wrong_dir");
    Ei_resolve = 1'b0;
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h10054), M_E, "ex_no_resolve");
    next_cycle(); idle(); Fi_PC = 32'h20000;
    // ID/EX carries {0, 0x20004}.
    resolve(32'h10060, 1'b0, 1'b0, 32'h10400);
    sample(pk(1'b0, 32'h0, 1'b0, 1'b0, 32'h10064), M_E, "ex_correct_nt");
    Ei_isJump = 1'b1;
    sample(pk(1'b0, 32'h0, 1'b0, 1'b1, 32'h10400), M_E, "ex_jump_forced");
    next_cycle(); idle(); Fi_PC = 32'h10060;
    sample(pk(1'b1, 32'h10400, 1'b0, 1'b0, 32'h0), M_F, "jump_alloc");
    resolve(32'h10060, 1'b0, 1'b0, 32'h1dead0);
    next_cycle(); idle(); Fi_PC = 32'h10060;
    sample(pk(1'b1, 32'h10400, 1'b0, 1'b0, 32'h0), M_F, "jump_alloc_st");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [W-1:0] e, m, o;
    string n;
    // Stall held two cycles keeps the taken prediction in IF/ID.
    next_cycle(); idle(); Fi_PC = 32'h10050;
    next_cycle(); idle(); Fi_PC = 32'h20000; Di_stall = 1'b1;
    next_cycle(); idle(); Fi_PC = 32'h20000; Di_stall = 1'b1;
    next_cycle(); idle(); Fi_PC = 32'h20000;
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0), M_ET, "stall_hold_d");
    next_cycle(); idle();
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0), M_ET, "stall_hold_e");
    next_cycle(); idle();
    sample(pk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0), M_ET, "stall_release");
    // Flush beats stall in the same cycle.
    next_cycle(); idle(); Fi_PC = 32'h10050;
    next_cycle(); idle(); Fi_PC = 32'h10050; Di_stall = 1'b1; Di_flush = 1'b1;
    next_cycle(); idle(); Fi_PC = 32'h20000;
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0), M_ET, "flush_prev_kept");
    next_cycle(); idle();
    sample(pk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0), M_ET, "stall_flush_prio");
    // ID/EX clear.
    next_cycle(); idle(); Fi_PC = 32'h10050;
    next_cycle(); idle(); Fi_PC = 32'h20000; Ei_flush = 1'b1;
    next_cycle(); idle();
    sample(pk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0), M_ET, "ex_flush");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_btb_flush();
    logic [W-1:0] e, m, o;
    string n;
    next_cycle(); idle(); Fi_PC = 32'h10050;
    sample(pk(1'b1, 32'h10300, 1'b0, 1'b0, 32'h0), M_F, "bflush_before");
    Ci_btbFlush = 1'b1;
    resolve(32'h10030, 1'b1, 1'b0, 32'h10500);
    sample(pk(1'b1, 32'h10300, 1'b0, 1'b0, 32'h0), M_F, "bflush_same_cycle");
    next_cycle(); idle(); Fi_PC = 32'h10050;
    sample(pk(1'b0, 32'h10054, 1'b0, 1'b0, 32'h0), M_F, "bflush_old");
    Fi_PC = 32'h10030;
    sample(pk(1'b0, 32'h10034, 1'b0, 1'b0, 32'h0), M_F, "bflush_update_dropped");
    Fi_PC = 32'h10060;
    sample(pk(1'b0, 32'h10064, 1'b0, 1'b0, 32'h0), M_F, "bflush_jump_entry");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e, m, o;
    string n;
    next_cycle(); idle(); Fi_PC = 32'h20000;
    resolve(32'h10030, 1'b1, 1'b0, 32'h10500);
    next_cycle(); idle(); Fi_PC = 32'h10030;
    sample(pk(1'b1, 32'h10500, 1'b0, 1'b0, 32'h0), M_F, "rst_setup_hit");
    next_cycle(); idle(); Fi_PC = 32'h20000;
    next_cycle(); idle();
    sample(pk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0), M_ET, "rst_pre");
    reset_x = 1'b0;
    Fi_PC = 32'h10030;
    sample(pk(1'b0, 32'h10034, 1'b0, 1'b0, 32'h0), M_F | M_ET | M_EM, "rst_async");
    next_cycle();
    reset_x = 1'b1;
    next_cycle(); idle(); Fi_PC = 32'h10030;
    sample(pk(1'b0, 32'h10034, 1'b0, 1'b0, 32'h0), M_F | M_ET | M_EM, "rst_table_cleared");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s: got %h required %h", n, o & m, e & m);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_alias();
    test_ex_compare();
    test_stall_flush();
    test_btb_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating counters. It supplies a predicted next PC to the IF-stage PC mux and carries that prediction through its own IF/ID and ID/EX registers. In EX it compares the prediction against the resolved outcome and raises a mispredict redirect. It is parametrised in address width, table depth and tag width, and updates the table at the same edge as resolution.

## Interface
Parameters:
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB entries; power of two, ≥ 2; IDX = log2(ENTRIES).
- TAG_BITS, 8, tag width taken from PC above the index field; IDX+2+TAG_BITS ≤ XLEN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_x  in  1  reset, asynchronous, active-low.
- Fi_PC  in  XLEN  current fetch PC (lookup address).
- Fo_predTaken  out  1  lookup hit with counter in a taken state.
- Fo_predTarget  out  XLEN  stored target on hit, else Fi_PC+4.
- Di_stall  in  1  hold IF/ID prediction register.
- Di_flush  in  1  clear IF/ID prediction register.
- Ei_flush  in  1  clear ID/EX prediction register.
- Ci_btbFlush  in  1  invalidate whole table (fence.i).
- Ei_resolve  in  1  EX holds a branch or jump this cycle.
- Ei_isJump  in  1  EX control transfer is unconditional (jal/jalr).
- Ei_taken  in  1  resolved direction (forced 1 when Ei_isJump).
- Ei_PC  in  XLEN  PC of the EX instruction.
- Ei_target  in  XLEN  resolved target (jalr already LSB-masked).
- Eo_predTaken  out  1  prediction carried into EX.
- Eo_mispredict  out  1  EX outcome differs from carried prediction.
- Eo_redirectPC  out  XLEN  correct next PC when Eo_mispredict.

## Operation
- Index = PC[IDX+1:2]; tag = PC[IDX+1+TAG_BITS:IDX+2]. Entry = {valid, tag, target[XLEN-1:0], ctr[1:0]}.
- Counter encodings: SNT=00, WNT=01, WT=10, ST=11; taken when ctr[1]=1.
- Lookup is combinational. hit = valid & tag match. Fo_predTaken = hit & ctr[1]. Fo_predTarget = Fo_predTaken ? target : Fi_PC+4.
- Prediction pipeline mirrors the datapath:
  - IF/ID register: {predTaken, predTarget}; enable ~Di_stall; clear Di_flush; clear has priority.
  - ID/EX register: always enabled; clear Ei_flush.
- Eo_mispredict = Ei_resolve & ((Eo_predTaken ≠ taken) | (taken & predTarget ≠ Ei_target)), where taken = Ei_taken | Ei_isJump. Forced 0 when Ei_resolve is 0.
- Eo_redirectPC = taken ? Ei_target : Ei_PC+4.
- Table update (rising edge, Ei_resolve=1), at entry index(Ei_PC):
  - Hit, taken: ctr saturating increment; target ← Ei_target.
  - Hit, not taken: ctr saturating decrement; target unchanged.
  - Miss, taken: allocate with valid=1, tag, target=Ei_target, ctr=WT (a jump allocates ST).
  - Miss, not taken: no change.
- Ci_btbFlush clears all valid bits at the edge and overrides a same-cycle update.

## Timing
- Reset: all valid=0, all ctr=WNT, targets 0, both pipeline registers 0. Outputs: Fo_predTaken=0, Fo_predTarget=Fi_PC+4, Eo_predTaken=0, Eo_mispredict=0.
- Lookup has 0-cycle latency. A prediction reaches the EX outputs 2 edges after fetch (plus any stall cycles).
- Update is visible to lookups from the edge after resolve. A same-cycle lookup of the same index sees the old contents.
- Aliasing: a differing tag at the same index is a miss; a taken resolve replaces the entry.
- Reset asserted mid-operation takes effect immediately (asynchronous) and returns the block to the reset state.

## Structure
- Shared package bp_pkg holds:
  - counter state localparams SNT/WNT/WT/ST;
  - functions bp_index(pc) and bp_tag(pc);
  - the ctr_next(ctr, taken) saturating function.
- Sub-module bp_table holds entry storage plus the read and write ports. Flush and reset live in it; the valid bits are flops, not RAM.
- Pipeline registers reuse the existing dffREC with enable/clear.

## Test plan
- Reset, then Fi_PC=0x10000 → Fo_predTaken=0, Fo_predTarget=0x10004.
- Resolve taken branch Ei_PC=0x10010, Ei_target=0x10100 → Eo_mispredict=1 and Eo_redirectPC=0x10100. Next cycle, lookup 0x10010 → predTaken=1, target=0x10100, ctr=WT.
- Two not-taken resolves at 0x10010 → ctr WT→WNT→SNT; lookup gives predTaken=0. Three taken resolves saturate the counter at ST.
- Alias 0x10010 with ENTRIES=16 and PC 0x10050 (same index, different tag) → lookup of 0x10050 misses. A taken resolve at 0x10050 evicts the entry, after which 0x10010 misses.
- With Di_stall held for 2 cycles, the prediction is held; Di_flush in the same cycle wins → ID register becomes 0. Ei_flush → Eo_predTaken=0.
- Ci_btbFlush together with a taken resolve → all lookups miss on the next cycle. Asserting reset_x low mid-stream clears Eo_predTaken immediately.
